// File: rtl/sim_mmio_pkg.sv
// Shared constants, state encodings and status-word layout for the sim MMIO front end.
package sim_mmio_pkg;

    // Word address (byte address >> 2) of the simulation MMIO register.
    localparam logic [29:0] MMIO_WORD_A   = 30'h0000_8000;

    // Byte lanes inside the MMIO word.
    localparam int          CHAR_OUT_LANE = 0;
    localparam int          SIM_CTRL_LANE = 2;

    localparam logic [1:0]  ST_RUN        = 2'd0;
    localparam logic [1:0]  ST_DRAIN      = 2'd1;
    localparam logic [1:0]  ST_HALT       = 2'd2;

    // Layout of the word returned by an MMIO read.
    typedef struct packed {
        logic        halt_pend;
        logic [9:0]  rsvd_hi;
        logic [4:0]  level;
        logic [15:0] rsvd_lo;
    } status_t;

    // The level field is only 5 bits wide; deeper FIFOs report 31 when fuller than that.
    function automatic logic [4:0] sat_level(input logic [31:0] lvl);
        return (lvl > 32'd31) ? 5'd31 : lvl[4:0];
    endfunction

endpackage

// File: rtl/sim_mmio_sync_fifo.sv
// Synchronous FIFO for the console byte stream: full/empty/level, no read bypass.
module sim_mmio_sync_fifo
    import sim_mmio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign full_o  = (level == LW'(DEPTH));
    assign empty_o = (level == '0);
    assign level_o = level;
    // Masked while empty so the head byte reads as zero out of reset.
    assign data_o  = empty_o ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/sim_mmio.sv
// LSU-to-RAM data front end that claims the simulation MMIO word for a console
// byte stream and a halt/exit-code mechanism with an optional watchdog.
//
//  state | meaning
//  RUN   | normal operation, watchdog counting, halt requests accepted
//  DRAIN | halt requested, waiting for the console FIFO to empty
//  HALT  | simulation finished; terminal until reset
module sim_mmio
    import sim_mmio_pkg::*;
#(
    parameter int unsigned CHAR_FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 0,
    parameter logic [7:0]  TIMEOUT_CODE    = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        rvalid_o,
    output logic        stall_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_rvalid_i,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        sim_halt_o,
    output logic [7:0]  sim_exit_code_o
);

    localparam int LW = $clog2(CHAR_FIFO_DEPTH) + 1;

    logic          mmio_hit;
    logic          rd_hit;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          ctrl_wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          wd_expire;
    logic [31:0]   wd_cnt;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [7:0]    exit_code;
    logic [7:0]    code_nxt;
    status_t       status;

    assign mmio_hit = ce_i && (addr_i[31:2] == MMIO_WORD_A);
    assign rd_hit   = mmio_hit && !we_i;
    assign push_req = mmio_hit && we_i && sel_i[CHAR_OUT_LANE];
    assign push     = push_req && !fifo_full;
    assign pop      = char_valid_o && char_ready_i;
    assign ctrl_wr  = mmio_hit && we_i && sel_i[SIM_CTRL_LANE];
    // Full is judged before any same-cycle pop, so a full FIFO always stalls.
    assign stall_o  = push_req && fifo_full;

    assign ram_ce_o   = ce_i && !mmio_hit;
    assign ram_we_o   = we_i;
    assign ram_addr_o = addr_i;
    assign ram_sel_o  = sel_i;
    assign ram_data_o = data_i;

    // Assemble the MMIO read word.
    always_comb begin
        status           = '0;
        status.halt_pend = (state != ST_RUN);
        status.level     = sat_level(32'(fifo_level));
    end

    assign data_o   = rd_hit ? status : ram_data_i;
    assign rvalid_o = rd_hit ? 1'b1 : (!mmio_hit && ram_rvalid_i);

    sim_mmio_sync_fifo #(
        .WIDTH (8),
        .DEPTH (CHAR_FIFO_DEPTH)
    ) u_char_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  (data_i[7:0]),
        .pop_i   (pop),
        .data_o  (char_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign char_valid_o = !fifo_empty;

    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog runs only while in RUN and freezes once a halt is pending.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wd_cnt <= '0;
        end else if (state == ST_RUN) begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    // Next-state logic; an explicit halt request wins over a same-cycle watchdog expiry.
    always_comb begin
        state_nxt = state;
        code_nxt  = exit_code;
        unique case (state)
            ST_RUN: begin
                if (ctrl_wr) begin
                    state_nxt = ST_DRAIN;
                    code_nxt  = data_i[23:16];
                end else if (wd_expire) begin
                    state_nxt = ST_DRAIN;
                    code_nxt  = TIMEOUT_CODE;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !push) state_nxt = ST_HALT;
            end
            default: ;
        endcase
    end

    // State and exit-code registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= ST_RUN;
            exit_code <= '0;
        end else begin
            state     <= state_nxt;
            exit_code <= code_nxt;
        end
    end

    assign sim_halt_o      = (state == ST_HALT);
    assign sim_exit_code_o = exit_code;

endmodule

// File: tb/tb_sim_mmio.sv
// Directed bench for sim_mmio with a byte-stream scoreboard and a small RAM model.
module tb_sim_mmio;

    localparam logic [31:0] MMIO  = 32'h0002_0000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wd_rst_n = 1'b0;
    logic        ce = 1'b0, we = 1'b0, char_ready = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  sel = '0;
    logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
    logic        rvalid, stall, ram_ce, ram_we, ram_rvalid;
    logic [3:0]  ram_sel;
    logic        char_valid, sim_halt;
    logic [7:0]  char_b, exit_code;

    logic [31:0] wd_rdata, wd_ram_addr, wd_ram_wdata;
    logic        wd_rvalid, wd_stall, wd_ram_ce, wd_ram_we, wd_char_valid, wd_halt;
    logic [3:0]  wd_ram_sel;
    logic [7:0]  wd_char, wd_code;

    int          checks = 0;
    int          failures = 0;
    int          dut_pops = 0;
    int          pops_base;
    logic        chk_rd = 1'b0;
    logic [31:0] exp_rd = '0;
    logic        seen_stall;
    logic [7:0]  exp_q[$];
    logic [31:0] ram_mem [0:255];

    always #5 clk = ~clk;

    sim_mmio dut (
        .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .addr_i(addr), .we_i(we), .sel_i(sel),
        .data_i(wdata), .data_o(rdata), .rvalid_o(rvalid), .stall_o(stall),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_sel_o(ram_sel),
        .ram_data_o(ram_wdata), .ram_data_i(ram_rdata), .ram_rvalid_i(ram_rvalid),
        .char_valid_o(char_valid), .char_o(char_b), .char_ready_i(char_ready),
        .sim_halt_o(sim_halt), .sim_exit_code_o(exit_code)
    );

    sim_mmio #(.TIMEOUT_CYCLES(100)) dut_wd (
        .clk_i(clk), .rst_n_i(wd_rst_n), .ce_i(1'b0), .addr_i(32'h0), .we_i(1'b0), .sel_i(4'h0),
        .data_i(32'h0), .data_o(wd_rdata), .rvalid_o(wd_rvalid), .stall_o(wd_stall),
        .ram_ce_o(wd_ram_ce), .ram_we_o(wd_ram_we), .ram_addr_o(wd_ram_addr), .ram_sel_o(wd_ram_sel),
        .ram_data_o(wd_ram_wdata), .ram_data_i(32'h0), .ram_rvalid_i(1'b0),
        .char_valid_o(wd_char_valid), .char_o(wd_char), .char_ready_i(1'b1),
        .sim_halt_o(wd_halt), .sim_exit_code_o(wd_code)
    );

    // Zero-latency RAM behind the pass-through port.
    initial for (int i = 0; i < 256; i++) ram_mem[i] = '0;
    always @(posedge clk) if (ram_ce && ram_we) ram_mem[ram_addr[9:2]] <= ram_wdata;
    assign ram_rdata  = ram_mem[ram_addr[9:2]];
    assign ram_rvalid = ram_ce && !ram_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cycle();
        logic hit, preq, evalid, estall, popping;
        #1;
        hit     = ce && (addr[31:2] == 30'h0000_8000);
        preq    = hit && we && sel[0];
        evalid  = (exp_q.size() != 0);
        estall  = preq && (exp_q.size() == DEPTH);
        popping = evalid && char_ready;
        seen_stall = stall;
        if (rst_n) begin
            check("stall", 32'(stall), 32'(estall));
            check("char_valid", 32'(char_valid), 32'(evalid));
            if (popping) check("char_byte", 32'(char_b), 32'(exp_q[0]));
            if (char_valid && char_ready) dut_pops++;
            if (chk_rd) begin
                check("rd_valid", 32'(rvalid), 32'h1);
                check("rd_data", rdata, exp_rd);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (popping) void'(exp_q.pop_front());
            if (preq && !estall) exp_q.push_back(wdata[7:0]);
        end
        #1;
    endtask

    task automatic idle(input int n);
        ce = 1'b0; we = 1'b0; sel = 4'h0; addr = '0; wdata = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
        cycle();
        ce = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic rd_mmio(input logic [31:0] exp);
        ce = 1'b1; we = 1'b0; addr = MMIO; sel = 4'hF;
        chk_rd = 1'b1; exp_rd = exp;
        cycle();
        chk_rd = 1'b0; ce = 1'b0;
    endtask

    // CHAR_OUT push that holds the access while stalled, bounded.
    task automatic push_hold(input logic [7:0] c);
        int n = 0;
        ce = 1'b1; we = 1'b1; addr = MMIO; sel = 4'b0001; wdata = {24'h0, c};
        do begin
            cycle();
            n++;
        end while (seen_stall && n < 8);
        check("push_landed", 32'(seen_stall), 32'h0);
        ce = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1; wd_rst_n = 1'b1;

        // Reset values and idle decode
        check("rst_char_o", 32'(char_b), 32'h0);
        check("rst_halt", 32'(sim_halt), 32'h0);
        check("rst_code", 32'(exit_code), 32'h0);
        check("idle_ram_ce", 32'(ram_ce), 32'h0);
        check("idle_rvalid", 32'(rvalid), 32'h0);

        // Watchdog instance: 100-cycle limit, halts on cycle 101 with code FF
        idle(100);
        check("wd_not_yet", 32'(wd_halt), 32'h0);
        idle(1);
        check("wd_halt", 32'(wd_halt), 32'h1);
        check("wd_code", 32'(wd_code), 32'hFF);

        // Disabled watchdog never halts
        idle(10000);
        check("wd_off_halt", 32'(sim_halt), 32'h0);

        // Pass-through write and read
        ce = 1'b1; we = 1'b1; addr = 32'h100; wdata = 32'h1234_5678; sel = 4'hF;
        #1;
        check("pt_w_ce", 32'(ram_ce), 32'h1);
        check("pt_w_we", 32'(ram_we), 32'h1);
        check("pt_w_addr", ram_addr, 32'h100);
        check("pt_w_sel", 32'(ram_sel), 32'hF);
        check("pt_w_data", ram_wdata, 32'h1234_5678);
        cycle();
        ce = 1'b1; we = 1'b0; addr = 32'h100; sel = 4'hF;
        #1;
        check("pt_r_ce", 32'(ram_ce), 32'h1);
        check("pt_r_valid", 32'(rvalid), 32'h1);
        check("pt_r_data", rdata, 32'h1234_5678);
        cycle();
        ce = 1'b1; we = 1'b0; addr = 32'h0002_0004;
        #1;
        check("next_word_ram_ce", 32'(ram_ce), 32'h1);
        addr = MMIO;
        #1;
        check("mmio_ram_ce", 32'(ram_ce), 32'h0);
        idle(1);

        // Console 'H','i' with ready high
        char_ready = 1'b1;
        wr(MMIO, 32'h48, 4'b0001);
        wr(MMIO, 32'h69, 4'b0001);
        idle(3);

        // Fill to full with ready low; the 17th push stalls
        char_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr(MMIO, 32'h41 + 32'(i), 4'b0001);
        wr(MMIO, 32'h51, 4'b0001);
        check("full_stall", 32'(seen_stall), 32'h1);
        rd_mmio(32'h0010_0000);
        pops_base = dut_pops;
        char_ready = 1'b1;
        push_hold(8'h51);
        idle(20);
        check("drain_count", 32'(dut_pops - pops_base), 32'd17);
        check("drained", 32'(char_valid), 32'h0);

        // Simultaneous push and pop keeps the level
        char_ready = 1'b0;
        wr(MMIO, 32'h61, 4'b0001);
        wr(MMIO, 32'h62, 4'b0001);
        char_ready = 1'b1;
        wr(MMIO, 32'h63, 4'b0001);
        char_ready = 1'b0;
        rd_mmio(32'h0002_0000);
        char_ready = 1'b1;
        idle(4);

        // Halt waits for the queued bytes to drain
        char_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(MMIO, 32'h30 + 32'(i), 4'b0001);
        wr(MMIO, 32'h002A_0000, 4'b0100);
        rd_mmio(32'h8003_0000);
        check("drain_no_halt", 32'(sim_halt), 32'h0);
        char_ready = 1'b1;
        idle(3);
        check("empty_no_halt", 32'(sim_halt), 32'h0);
        idle(1);
        check("halt", 32'(sim_halt), 32'h1);
        check("halt_code", 32'(exit_code), 32'h2A);
        wr(MMIO, 32'h0005_0000, 4'b0100);
        idle(1);
        check("second_ctrl_ignored", 32'(exit_code), 32'h2A);
        wr(MMIO, 32'h5A, 4'b0001);
        idle(2);
        check("halt_sticky", 32'(sim_halt), 32'h1);
        rd_mmio(32'h8000_0000);

        // Combined CHAR_OUT + SIM_CTRL write: push lands before the drain check
        reset_pulse();
        check("rst2_halt", 32'(sim_halt), 32'h0);
        check("rst2_code", 32'(exit_code), 32'h0);
        char_ready = 1'b0;
        wr(MMIO, 32'h0033_0047, 4'b0101);
        idle(1);
        check("combo_no_halt", 32'(sim_halt), 32'h0);
        rd_mmio(32'h8001_0000);
        char_ready = 1'b1;
        idle(1);
        check("combo_pop_no_halt", 32'(sim_halt), 32'h0);
        idle(1);
        check("combo_halt", 32'(sim_halt), 32'h1);
        check("combo_code", 32'(exit_code), 32'h33);

        // Reset in the middle of DRAIN with bytes queued
        reset_pulse();
        char_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(MMIO, 32'h70 + 32'(i), 4'b0001);
        wr(MMIO, 32'h0011_0000, 4'b0100);
        rd_mmio(32'h8005_0000);
        reset_pulse();
        check("mid_rst_valid", 32'(char_valid), 32'h0);
        check("mid_rst_char", 32'(char_b), 32'h0);
        check("mid_rst_halt", 32'(sim_halt), 32'h0);
        check("mid_rst_code", 32'(exit_code), 32'h0);
        rd_mmio(32'h0000_0000);
        wr(MMIO, 32'h0044_0000, 4'b0100);
        idle(1);
        check("fresh_halt", 32'(sim_halt), 32'h1);
        check("fresh_code", 32'(exit_code), 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
